// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register index width, forward select
// encodings and the per-stage tag layouts used by the hazard controller.
package forward_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Operand source for an EX ALU input.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
    } ex_tag_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
    } stage_tag_t;

    // True when a stage will write a real (non-x0) architectural register.
    function automatic logic writes_reg(input stage_tag_t t);
        return t.valid && t.reg_write && (t.rd != '0);
    endfunction

endpackage

// File: rtl/forward_hazard_ctrl_fwd_select.sv
// Selects the operand source for one EX source register from the
// MEM and WB stage tags. MEM wins over WB because it holds the newer value;
// a load in MEM has no data yet and is never a forwarding source.
module fwd_select
    import forward_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  stage_tag_t       mem_tag,
    input  stage_tag_t       wb_tag,
    output fwd_sel_e         sel
);

    // The load flag only matters in MEM; at WB load data is available.
    logic unused_wb_mem_read;
    assign unused_wb_mem_read = wb_tag.mem_read;

    // Priority select: MEM ALU result, then WB value, else register file.
    always_comb begin
        sel = FWD_REG;
        if (writes_reg(mem_tag) && !mem_tag.mem_read && (mem_tag.rd == rs)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb_tag) && (wb_tag.rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard control for a 5-stage pipeline. Tracks instruction
// tags through EX/MEM/WB, drives ALU operand selects, detects load-use
// hazards (one-cycle stall) and flushes on taken branches.
module forward_hazard_ctrl
    import forward_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             flush,
    output logic [31:0]      stall_count
);

    ex_tag_t     ex_q, ex_d;
    stage_tag_t  mem_q, mem_d;
    stage_tag_t  wb_q, wb_d;
    logic [31:0] stall_count_q, stall_count_d;

    fwd_sel_e    sel_a, sel_b;
    logic        load_use_hit;

    // Load-use detection against the current ID sources; a taken branch
    // squashes the consumer so no stall is needed. Reset masks it so the
    // stall never survives into or out of reset.
    always_comb begin
        load_use_hit = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                       ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
        flush        = branch_taken;
        stall        = load_use_hit && !branch_taken && !rst;
    end

    fwd_select u_fwd_a (
        .rs      (ex_q.rs1),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_a)
    );

    fwd_select u_fwd_b (
        .rs      (ex_q.rs2),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_b)
    );

    // Operand selects only apply to a real EX instruction outside reset.
    always_comb begin
        forward_a = FWD_REG;
        forward_b = FWD_REG;
        if (ex_q.valid && !rst) begin
            forward_a = sel_a;
            forward_b = sel_b;
        end
    end

    // Next tags: EX takes ID (or a bubble on stall/flush), MEM/WB shift on.
    always_comb begin
        ex_d.valid     = id_valid;
        ex_d.rs1       = id_rs1;
        ex_d.rs2       = id_rs2;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        if (flush || stall) begin
            ex_d.valid     = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
        end

        mem_d.valid     = ex_q.valid;
        mem_d.rd        = ex_q.rd;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.mem_read  = ex_q.mem_read;

        wb_d = mem_q;
    end

    // Saturating count of load-use stall cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Tag pipeline and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
